data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
- Next-generation data memory for the processor datapath: parametrised word width and depth.
- Adds byte-lane write enables, a valid/ready request handshake, a registered (1-cycle) read response, and a hardware clear sequencer.
- The sequencer fills every entry with a constant, replacing file-based preload for reset initialisation.
- Sits between the load/store unit and the memory array; one access per cycle.

Parameters:
- W, 8, data word width in bits; must be a multiple of 8.
- A, 8, address width; depth = 2**A entries.
- INIT_VAL, 0, W-bit value written to every entry by the clear sweep.

Ports:
- Clk  input  1  clock; all state updates on posedge.
- ResetN  input  1  asynchronous, active-low reset.
- ClearReq  input  1  pulse: start a clear sweep; sampled only in IDLE.
- ReqValid  input  1  request present.
- ReqReady  output  1  controller accepts a request this cycle.
- WriteEn  input  1  1 = write request, 0 = read request.
- ByteEn  input  W/8  per-byte write mask; ignored for reads.
- DataAddress  input  A  word address.
- DataIn  input  W  write data.
- RespValid  output  1  DataOut holds read data for the request accepted in the previous cycle.
- DataOut  output  W  registered read data.
- Busy  output  1  clear sweep in progress.

Behaviour:
- Reset values (while ResetN = 0): ReqReady = 0, RespValid = 0, DataOut = 0, Busy = 0, state = CLEAR (with DATAMEM_CLEAR_EN) or IDLE (without), sweep pointer = 0.
- The array itself is not reset asynchronously.
- States: CLEAR, IDLE.
- CLEAR:
  - Each cycle writes INIT_VAL to Core[ptr], then increments ptr.
  - Busy = 1, ReqReady = 0.
  - After writing entry 2**A-1, ptr wraps to 0 and the next state is IDLE.
  - The sweep takes exactly 2**A cycles after ResetN rises.
- IDLE:
  - ReqReady = !ClearReq (combinational).
  - ClearReq = 1 moves the next state to CLEAR; ptr = 0; any ReqValid in that cycle is not accepted.
- Acceptance: a request is accepted when ReqValid && ReqReady at posedge.
- Write:
  - For each lane i with ByteEn[i] = 1, Core[addr][8i+7:8i] <= DataIn[8i+7:8i].
  - Lanes with ByteEn[i] = 0 are unchanged.
  - ByteEn = 0 is a legal no-op write.
  - RespValid = 0 the next cycle.
- Read:
  - DataOut <= Core[addr] at the accepting edge; RespValid = 1 for exactly the following cycle.
  - DataOut holds its value until the next accepted read.
  - RespValid = 0 in every other cycle.
- Throughput: one request per cycle, back-to-back.
- Read directly after a write to the same address (next cycle) returns the newly written data. No bypass is needed, since the write completes at the earlier edge.
- Only one request per cycle, so there is no same-cycle read/write conflict.
- Reset mid-sweep or mid-read:
  - Asserting ResetN = 0 aborts immediately; outputs return to reset values.
  - A sweep restarts from entry 0 after release; partially cleared contents are overwritten.
- ClearReq while in CLEAR is ignored; the sweep is not restarted.
- Address out of range is impossible by construction (depth = 2**A).

Optional Feature:
- Macro: DATAMEM_CLEAR_EN.
- Defined:
  - The CLEAR state and sweep exist as above.
  - ResetN release and ClearReq trigger sweeps.
- Undefined:
  - No sweep logic; state is always IDLE; Busy is tied to 0; ClearReq is ignored.
  - ReqReady = 1 from the first cycle after ResetN rises.
  - Initial array contents are undefined (X in simulation).

Test Plan:
- Clear after reset (A=8, DATAMEM_CLEAR_EN, INIT_VAL=8'hA5): release ResetN -> Busy=1 and ReqReady=0 for exactly 256 cycles; then reads of addresses 0, 127 and 255 return 8'hA5 with RespValid one cycle after acceptance.
- Byte-lane write (W=32):
  - Write 32'h11223344 with ByteEn=4'b1111 to addr 5.
  - Then write 32'hAABBCCDD with ByteEn=4'b0101 to addr 5.
  - Read addr 5 -> DataOut=32'h11BB33DD.
- Back-to-back traffic: write addr 3=8'h7E, then read addr 3 the next cycle -> RespValid=1 with DataOut=8'h7E; a read stream to addresses 0..3 in consecutive cycles returns data in order, one per cycle.
- Clear request priority: in IDLE drive ClearReq=1 and ReqValid=1 (write addr 9=8'h55) in the same cycle -> ReqReady=0, write not accepted; after the 256-cycle sweep, addr 9 reads INIT_VAL.
- Reset mid-sweep: assert ResetN=0 at sweep cycle 100 for 2 cycles -> outputs immediately return to reset values; after release, Busy stays high for a full 256 cycles; addr 200 reads INIT_VAL.
- Macro off: build without DATAMEM_CLEAR_EN -> ReqReady=1 on the first cycle after reset; Busy stays 0; pulsing ClearReq has no effect; a written value is preserved.

Source files
------------

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_ctrl
// Brief   : Data memory controller between the load/store unit and the array.
//           Per-byte write enables, valid/ready request handshake, 1-cycle
//           registered read response, and an optional hardware clear sweep
//           that fills every entry with INIT_VAL.
// Options : `define DATAMEM_CLEAR_EN to build the clear sequencer (sweep after
//           reset release and on ClearReq). Without it the controller is
//           always idle and the array starts undefined.
// Rev     : 1.0  initial release
// ============================================================================
module data_mem_ctrl #(
  parameter int           W        = 8,   // word width, multiple of 8
  parameter int           A        = 8,   // address width, depth = 2**A
  parameter logic [W-1:0] INIT_VAL = '0   // value written by the clear sweep
) (
  input  logic           Clk,
  input  logic           ResetN,
  input  logic           ClearReq,
  input  logic           ReqValid,
  output logic           ReqReady,
  input  logic           WriteEn,
  input  logic [W/8-1:0] ByteEn,
  input  logic [A-1:0]   DataAddress,
  input  logic [W-1:0]   DataIn,
  output logic           RespValid,
  output logic [W-1:0]   DataOut,
  output logic           Busy
);

  localparam int C_LANES = W / 8;
  localparam int C_DEPTH = 1 << A;

  logic [W-1:0] r_core [C_DEPTH];

  logic         w_accept;
  logic         w_wr_accept;
  logic         w_rd_accept;
  logic         w_clr_wr;
  logic [A-1:0] w_clr_addr;

`ifdef DATAMEM_CLEAR_EN
  localparam logic [0:0]   S_IDLE     = 1'b0;
  localparam logic [0:0]   S_CLEAR    = 1'b1;
  localparam logic [A-1:0] C_PTR_ONE  = {{(A-1){1'b0}}, 1'b1};
  localparam logic [A-1:0] C_PTR_LAST = '1;

  logic [0:0]   r_state;
  logic [0:0]   w_state_nxt;
  logic [A-1:0] r_ptr;
  logic [A-1:0] w_ptr_nxt;

  // State and sweep pointer register; reset lands in CLEAR so every release starts a sweep
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_state <= S_CLEAR;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Next state: walk every entry once, then idle; ClearReq in IDLE restarts from entry 0
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      S_CLEAR: begin
        w_ptr_nxt = r_ptr + C_PTR_ONE;
        if (r_ptr == C_PTR_LAST) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        if (ClearReq) begin
          w_state_nxt = S_CLEAR;
          w_ptr_nxt   = '0;
        end
      end
    endcase
  end

  // Outputs: sweep owns the array in CLEAR; a clear request blocks the same-cycle request
  always_comb begin
    ReqReady = 1'b0;
    Busy     = 1'b0;
    w_clr_wr = 1'b0;
    case (r_state)
      S_CLEAR: begin
        Busy     = ResetN;
        w_clr_wr = 1'b1;
      end
      default: begin
        ReqReady = ResetN & ~ClearReq;
      end
    endcase
  end

  assign w_clr_addr = r_ptr;
`else
  // Sweep hardware absent: clear inputs and the init value have no effect
  logic w_unused_cfg;
  assign w_unused_cfg = ClearReq ^ (^INIT_VAL);

  assign ReqReady   = ResetN;
  assign Busy       = 1'b0;
  assign w_clr_wr   = 1'b0;
  assign w_clr_addr = '0;
`endif

  assign w_accept    = ReqValid & ReqReady;
  assign w_wr_accept = w_accept & WriteEn;
  assign w_rd_accept = w_accept & ~WriteEn;

  // Array write port: sweep writes full words, requests write only the enabled byte lanes
  always_ff @(posedge Clk) begin
    if (w_clr_wr) begin
      r_core[w_clr_addr] <= INIT_VAL;
    end else if (w_wr_accept) begin
      for (int i = 0; i < C_LANES; i++) begin
        if (ByteEn[i]) begin
          r_core[DataAddress][8*i +: 8] <= DataIn[8*i +: 8];
        end
      end
    end
  end

  // Read response: capture the word at the accepting edge, flag it valid for one cycle
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      RespValid <= 1'b0;
      DataOut   <= '0;
    end else begin
      RespValid <= w_rd_accept;
      if (w_rd_accept) begin
        DataOut <= r_core[DataAddress];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_data_mem_ctrl
// Brief   : Scoreboard bench for data_mem_ctrl. Stimulus pushes expected read
//           responses; an independent monitor pops them when RespValid shows.
//           Follows the DATAMEM_CLEAR_EN setting of the build.
// Rev     : 1.0  initial release
// ============================================================================
module tb_data_mem_ctrl;

  localparam int           W     = 32;
  localparam int           A     = 8;
  localparam int           NL    = W / 8;
  localparam int           DEPTH = 1 << A;
  localparam logic [W-1:0] INIT  = 32'hA5C3_5A3C;

  logic          Clk = 1'b0;
  logic          ResetN = 1'b0;
  logic          ClearReq = 1'b0;
  logic          ReqValid = 1'b0;
  logic          ReqReady;
  logic          WriteEn = 1'b0;
  logic [NL-1:0] ByteEn = '0;
  logic [A-1:0]  DataAddress = '0;
  logic [W-1:0]  DataIn = '0;
  logic          RespValid;
  logic [W-1:0]  DataOut;
  logic          Busy;

  data_mem_ctrl #(.W(W), .A(A), .INIT_VAL(INIT)) dut (
    .Clk(Clk), .ResetN(ResetN), .ClearReq(ClearReq), .ReqValid(ReqValid),
    .ReqReady(ReqReady), .WriteEn(WriteEn), .ByteEn(ByteEn),
    .DataAddress(DataAddress), .DataIn(DataIn), .RespValid(RespValid),
    .DataOut(DataOut), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int           due;
    logic [W-1:0] data;
  } exp_t;
  exp_t sb[$];

  // Reference memory: word contents plus whether the word is fully defined
  logic [W-1:0] mdl   [DEPTH];
  bit           known [DEPTH];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_fill_init();
    for (int i = 0; i < DEPTH; i++) begin
      mdl[i]   = INIT;
      known[i] = 1'b1;
    end
  endtask

  // Monitor: every RespValid must match the oldest outstanding read, due this cycle
  always @(negedge Clk) begin
    while (sb.size() > 0 && sb[0].due < cyc) begin
      n_vec++;
      n_err++;
      $display("FAIL resp_missing: got no response, expected %h at cycle %0d", sb[0].data, sb[0].due);
      void'(sb.pop_front());
    end
    if (RespValid !== 1'b0) begin
      n_vec++;
      if (sb.size() == 0 || sb[0].due != cyc) begin
        n_err++;
        $display("FAIL resp_spurious: got RespValid=%b data %h, expected no response (cycle %0d)",
                 RespValid, DataOut, cyc);
      end else begin
        if (DataOut !== sb[0].data) begin
          n_err++;
          $display("FAIL resp_data: got %h, expected %h (cycle %0d)", DataOut, sb[0].data, cyc);
        end
        void'(sb.pop_front());
      end
    end
  end

  // One request slot: drive at negedge, check ready, update the model if accepted
  task automatic op(input bit v, input bit we, input logic [NL-1:0] be,
                    input logic [A-1:0] ad, input logic [W-1:0] d, input bit clr);
    bit exp_rdy;
    @(negedge Clk);
    ReqValid = v; WriteEn = we; ByteEn = be; DataAddress = ad; DataIn = d; ClearReq = clr;
`ifdef DATAMEM_CLEAR_EN
    exp_rdy = !clr;
`else
    exp_rdy = 1'b1;
`endif
    #1;
    check("req_ready", W'(ReqReady), W'(exp_rdy));
    if (v && exp_rdy) begin
      if (we) begin
        for (int i = 0; i < NL; i++) begin
          if (be[i]) mdl[ad][8*i +: 8] = d[8*i +: 8];
        end
        if (be == '1) known[ad] = 1'b1;
      end else begin
        sb.push_back('{due: cyc + 1, data: mdl[ad]});
      end
    end
  endtask

  task automatic idle();
    op(1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic rd(input logic [A-1:0] ad);
    op(1'b1, 1'b0, '0, ad, '0, 1'b0);
  endtask

  task automatic wr(input logic [A-1:0] ad, input logic [W-1:0] d, input logic [NL-1:0] be);
    op(1'b1, 1'b1, be, ad, d, 1'b0);
  endtask

  // Counts consecutive Busy cycles starting at the current sample point
  task automatic count_sweep(input string name);
    int n = 0;
    int rdy_bad = 0;
    int guard = 0;
    while (Busy === 1'b1 && guard < 4 * DEPTH) begin
      n++;
      if (ReqReady !== 1'b0) rdy_bad++;
      @(negedge Clk);
      #1;
      guard++;
    end
    check({name, "_busy_cycles"}, W'(n), W'(DEPTH));
    check({name, "_ready_low"}, W'(rdy_bad), W'(0));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ReqReady"},  W'(ReqReady),  W'(0));
    check({name, "_RespValid"}, W'(RespValid), W'(0));
    check({name, "_DataOut"},   DataOut,       '0);
    check({name, "_Busy"},      W'(Busy),      W'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mdl[i]   = '0;
      known[i] = 1'b0;
    end

    ResetN = 1'b0;
    repeat (3) @(negedge Clk);
    #1;
    check_reset_outputs("reset");

`ifdef DATAMEM_CLEAR_EN
    @(negedge Clk);
    ResetN = 1'b1;
    #1;
    count_sweep("reset_sweep");
    model_fill_init();
    rd(8'd0); rd(8'd127); rd(8'd255);
`else
    @(negedge Clk);
    ResetN = 1'b1;
    @(negedge Clk);
    #1;
    check("ready_after_reset", W'(ReqReady), W'(1));
    check("busy_after_reset", W'(Busy), W'(0));
`endif

    // Byte lanes: full write, partial overwrite, then a no-op write
    wr(8'd5, 32'h1122_3344, 4'b1111);
    wr(8'd5, 32'hAABB_CCDD, 4'b0101);
    rd(8'd5);
    wr(8'd5, 32'hFFFF_FFFF, 4'b0000);
    rd(8'd5);

    // Back-to-back write then read, then a read stream
    wr(8'd3, 32'h0000_007E, 4'b1111);
    rd(8'd3);
`ifndef DATAMEM_CLEAR_EN
    wr(8'd0, 32'h0BAD_F00D, 4'b1111);
    wr(8'd1, 32'h1234_5678, 4'b1111);
    wr(8'd2, 32'hCAFE_0002, 4'b1111);
`endif
    rd(8'd0); rd(8'd1); rd(8'd2); rd(8'd3);
    idle();

`ifdef DATAMEM_CLEAR_EN
    // Clear request wins over a same-cycle write
    op(1'b1, 1'b1, 4'b1111, 8'd9, 32'h0000_0055, 1'b1);
    model_fill_init();
    @(negedge Clk);
    ReqValid = 1'b0; ClearReq = 1'b0;
    #1;
    count_sweep("clear_sweep");
    rd(8'd9);
    idle();

    // Reset in the middle of a sweep
    op(1'b0, 1'b0, '0, '0, '0, 1'b1);
    @(negedge Clk);
    ClearReq = 1'b0;
    repeat (99) @(negedge Clk);
    #1;
    check("busy_mid_sweep", W'(Busy), W'(1));
    ResetN = 1'b0;
    #1;
    check_reset_outputs("mid_sweep_reset");
    repeat (2) @(negedge Clk);
    ResetN = 1'b1;
    #1;
    count_sweep("restart_sweep");
    model_fill_init();
    rd(8'd200);
    idle();
`else
    // ClearReq has no effect without the sequencer
    wr(8'd9, 32'h0000_0055, 4'b1111);
    op(1'b0, 1'b0, '0, '0, '0, 1'b1);
    check("busy_on_clearreq", W'(Busy), W'(0));
    idle();
    check("busy_after_clearreq", W'(Busy), W'(0));
    rd(8'd9);
    idle();
`endif

    // Randomised traffic with idle bubbles and address collisions
    for (int k = 0; k < 300; k++) begin
      bit            v;
      bit            we;
      logic [A-1:0]  ad;
      logic [NL-1:0] be;
      logic [W-1:0]  d;
      v  = ($urandom_range(0, 3) != 0);
      we = $urandom_range(0, 1);
      ad = ($urandom_range(0, 3) == 0) ? A'($urandom_range(0, DEPTH - 1)) : A'($urandom_range(0, 15));
      be = NL'($urandom_range(0, (1 << NL) - 1));
      d  = W'($urandom);
      if (v && !we && !known[ad]) begin
        we = 1'b1;
        be = '1;
      end
      op(v, we, be, ad, d, 1'b0);
    end
    idle();

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge Clk);
    #1;
    check("scoreboard_drained", W'(sb.size()), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
